// File: rtl/sq_seq_pkg.sv
// Shared types for the square-wave sequencer: FSM states, program-table entry
// layout and the default prescale ratio.
package sq_seq_pkg;

    localparam int UNIT_TICK_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] on;
        logic [3:0] off;
        logic [3:0] rep;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{on: 4'd1, off: 4'd1, rep: 4'd0};

    // An entry with a zero-length phase cannot be played.
    function automatic logic entry_valid(input entry_t e);
        return (e.on != 4'd0) && (e.off != 4'd0);
    endfunction

endpackage

// File: rtl/sq_unit_tick.sv
// Time-unit prescaler: pulses tick once every UNIT_TICK enabled cycles.
module sq_unit_tick
    import sq_seq_pkg::*;
#(
    parameter int UNIT_TICK = UNIT_TICK_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(UNIT_TICK);

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == CW'(UNIT_TICK - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/sq_wave_sequencer.sv
// Programmable square-wave sequencer: plays a table of {on, off, rep} segments,
// optionally looping, with start/stop control and period/done/err pulses.
module sq_wave_sequencer
    import sq_seq_pkg::*;
#(
    parameter int UNIT_TICK = UNIT_TICK_DEFAULT,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [3:0]               wr_on,
    input  logic [3:0]               wr_off,
    input  logic [3:0]               wr_rep,
    input  logic [$clog2(DEPTH)-1:0] seg_last,
    input  logic                     loop_en,
    input  logic                     start,
    input  logic                     stop,
    output logic                     sq_wave,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] seg_idx,
    output logic                     period_done,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);

    state_t        state_reg;
    entry_t        tbl_reg [DEPTH];
    entry_t        cur_reg;
    logic [AW-1:0] seg_idx_reg;
    logic [AW-1:0] seg_last_reg;
    logic [3:0]    rep_cnt_reg;
    logic [3:0]    unit_cnt_reg;

    logic          tick;
    logic          high_end;
    logic          period_end;
    logic          load_req;
    logic          load_bad;
    logic          rep_again;
    logic          finish;
    logic [AW-1:0] load_idx;
    entry_t        load_entry;

    sq_unit_tick #(.UNIT_TICK(UNIT_TICK)) u_unit_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (stop || (state_reg == IDLE)),
        .en      (state_reg != IDLE),
        .tick    (tick)
    );

    // Decide what happens at the end of the current period (or on start).
    always_comb begin
        high_end   = (state_reg == HIGH) && tick && (unit_cnt_reg == cur_reg.on - 4'd1);
        period_end = (state_reg == LOW) && tick && (unit_cnt_reg == cur_reg.off - 4'd1);
        load_req   = 1'b0;
        load_idx   = '0;
        rep_again  = 1'b0;
        finish     = 1'b0;
        if (state_reg == IDLE) begin
            load_req = start && !stop;
        end else if (period_end && !stop) begin
            if (rep_cnt_reg < cur_reg.rep) begin
                rep_again = 1'b1;
            end else if (seg_idx_reg < seg_last_reg) begin
                load_req = 1'b1;
                load_idx = seg_idx_reg + AW'(1);
            end else if (loop_en) begin
                load_req = 1'b1;
            end else begin
                finish = 1'b1;
            end
        end
        load_entry = tbl_reg[load_idx];
        load_bad   = load_req && !entry_valid(load_entry);
    end

    assign sq_wave     = (state_reg == HIGH);
    assign busy        = (state_reg != IDLE);
    assign seg_idx     = seg_idx_reg;
    assign period_done = period_end && !stop;
    assign done        = finish;
    assign err         = load_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) tbl_reg[i] <= ENTRY_RESET;
        end else if (wr_en) begin
            tbl_reg[wr_addr] <= '{on: wr_on, off: wr_off, rep: wr_rep};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cur_reg      <= ENTRY_RESET;
            seg_idx_reg  <= '0;
            seg_last_reg <= '0;
            rep_cnt_reg  <= '0;
            unit_cnt_reg <= '0;
        end else if (stop || load_bad || finish) begin
            state_reg    <= IDLE;
            seg_idx_reg  <= '0;
            rep_cnt_reg  <= '0;
            unit_cnt_reg <= '0;
        end else if (load_req) begin
            state_reg    <= HIGH;
            cur_reg      <= load_entry;
            seg_idx_reg  <= load_idx;
            rep_cnt_reg  <= '0;
            unit_cnt_reg <= '0;
            if (state_reg == IDLE) seg_last_reg <= seg_last;
        end else if (rep_again) begin
            state_reg    <= HIGH;
            rep_cnt_reg  <= rep_cnt_reg + 4'd1;
            unit_cnt_reg <= '0;
        end else if (high_end) begin
            state_reg    <= LOW;
            unit_cnt_reg <= '0;
        end else if (tick) begin
            unit_cnt_reg <= unit_cnt_reg + 4'd1;
        end
    end

endmodule

// File: doc/sq_wave_sequencer.md
SQ_WAVE_SEQUENCER -- requirements
Module: sq_wave_sequencer

Interface
REQ-001 Parameter UNIT_TICK, default 10: clk cycles per time unit (100 ns at 100 MHz); SHALL be >= 2.
REQ-002 Parameter DEPTH, default 4: number of program-table entries; SHALL be a power of two.
REQ-003 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_n  in  1  reset SHALL be asynchronous and active-low.
REQ-005 wr_en  in  1  table write strobe, one entry per cycle.
REQ-006 wr_addr  in  log2(DEPTH)  table entry index.
REQ-007 wr_on / wr_off / wr_rep  in  4 each  HIGH units, LOW units, extra-repeat count.
REQ-008 seg_last  in  log2(DEPTH)  index of final segment; sampled only when start is accepted.
REQ-009 loop_en  in  1  after seg_last, restart at entry 0; sampled live.
REQ-010 start / stop  in  1 each  single-cycle command pulses.
REQ-011 sq_wave  out  1  registered waveform output.
REQ-012 busy  out  1  high in any non-IDLE state.
REQ-013 seg_idx  out  log2(DEPTH)  active entry index.
REQ-014 period_done / done / err  out  1 each  single-cycle pulses.

Function
REQ-015 FSM states SHALL be IDLE, HIGH, LOW; sq_wave SHALL be 1 exactly when state is HIGH.
REQ-016 A write SHALL update table[wr_addr] at the next edge in any state; the active segment SHALL use latched copies, so writes affect only later entry loads.
REQ-017 A start in IDLE without stop SHALL load entry 0; the next cycle SHALL be HIGH with busy=1, seg_idx=0, rep_cnt=0, prescaler=0.
REQ-018 A start while busy SHALL be ignored; a start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-019 Entry load: if on==0 or off==0, err SHALL pulse in that cycle, the next state SHALL be IDLE, and done SHALL NOT pulse.
REQ-020 HIGH SHALL last exactly on*UNIT_TICK cycles; LOW SHALL last exactly off*UNIT_TICK cycles; the prescaler SHALL count only while busy.
REQ-021 period_done SHALL assert combinationally during the last LOW cycle of every period.
REQ-022 At period end: if rep_cnt<rep, increment rep_cnt and re-enter HIGH; else if seg_idx<seg_last, advance seg_idx, load the entry, clear rep_cnt; else if loop_en, seg_idx=0 and load; else go to IDLE with done pulsing in that last LOW cycle.
REQ-023 Each segment SHALL emit rep+1 periods, and the transition to the next period or segment SHALL add no gap cycle.
REQ-024 seg_idx SHALL wrap from DEPTH-1 to 0 only through loop_en; seg_last SHALL be latched at start.
REQ-025 stop SHALL have highest priority: the next cycle SHALL be IDLE with sq_wave=0 and busy=0, with no done and no period_done for the partial period.

Reset
REQ-026 Under reset_n=0, state SHALL be IDLE; sq_wave, busy, seg_idx, period_done, done, err, rep_cnt and prescaler SHALL be 0.
REQ-027 Under reset_n=0, every table entry SHALL be on=1, off=1, rep=0.
REQ-028 Reset asserted mid-operation SHALL abort immediately (asynchronously) with the values of REQ-026.

Structure
REQ-029 Package sq_seq_pkg SHALL hold the state enum, the entry struct {on, off, rep} and the UNIT_TICK default.
REQ-030 The unit prescaler SHALL be a sub-module sq_unit_tick with ports clk, reset_n, clr, en and a tick output.
REQ-031 Target size SHALL be 120-400 RTL lines.

Verification (UNIT_TICK=10)
REQ-032 Entry0={3,2,0}, seg_last=0, start -> sq_wave high 30 cycles then low 20; period_done and done pulse in cycle 50; busy=0 in cycle 51.
REQ-033 Entry0={1,1,2}, entry1={2,1,0}, seg_last=1 -> three 10/10 periods, then one 20/10 period with no gap; seg_idx changes 0->1 at cycle 60; done at cycle 90.
REQ-034 Entry0={1,1,0}, seg_last=0, loop_en=1 -> continuous 10/10 wave with no done; stop at cycle 25 -> sq_wave=0 and busy=0 at cycle 26, no done.
REQ-035 Entry1={0,3,0}, entry0 valid, seg_last=1 -> err pulses at segment-1 load, IDLE next cycle, done never asserts.
REQ-036 Rewrite entry0 to {5,5,0} mid-HIGH of a {2,2,1} program -> both current periods stay 20/20; the next run uses 50/50.
REQ-037 reset_n asserted low mid-LOW -> all outputs 0 immediately; after release, start runs from entry 0 with table values {1,1,0}.
